logicgates_checker: RTL
=======================

# logicgates_checker

Self-checking stimulus/response engine for the two-input logic gate block. On `start` it drives the four input vectors (a,b = 00, 01, 10, 11) onto the gate block and samples its seven outputs after a programmable settle time. It compares each sample against the expected truth table and reports a saturating mismatch count plus a pass flag. It is the response-side counterpart to the gate block: it consumes y1..y7 and produces the a/b stimulus that feeds them.

## Interface
- `SETTLE`, default 2: cycles `a`/`b` are held before `y` is sampled; legal range 1..255.
- `ERR_W`, default 8: width of `err_cnt`; legal minimum 1.

- `clk`  in  1  rising-edge clock
- `rst_n`  in  1  asynchronous active-low reset
- `start`  in  1  begins a run when sampled high in IDLE
- `a`  out  1  stimulus to gate block, registered
- `b`  out  1  stimulus to gate block, registered
- `y`  in  7  gate outputs; y[0]=y1 … y[6]=y7
- `busy`  out  1  high from APPLY through CHECK of the last vector
- `done`  out  1  one-cycle pulse when a run completes
- `pass`  out  1  high when the completed run had zero mismatches
- `err_cnt`  out  ERR_W  saturating count of mismatched output bits
- `fail_vec`  out  2  {a,b} of the first failing vector; present only with `LGC_FAIL_CAPTURE_EN`
- `fail_mask`  out  7  (y ^ expected) at the first failing vector; present only with `LGC_FAIL_CAPTURE_EN`

## Operation
- Expected outputs: y1=a&b, y2=a|b, y3=~(a&b), y4=~(a|b), y5=a^b, y6=~(a^b), y7=~a.
- FSM states: IDLE, APPLY, WAIT, CHECK, DONE.
  - IDLE: `start`=1 → APPLY. Clears `err_cnt`, `pass`, vector index, and capture registers.
  - APPLY (1 cycle): a,b ← vector index.
  - WAIT: stays SETTLE cycles, counted by a down-counter.
  - CHECK (1 cycle): samples `y`, computes mismatch = popcount(y ^ expected), range 0..7, and adds it to `err_cnt`.
  - CHECK exits: if index < 3, increment index → APPLY; else → DONE.
  - DONE (1 cycle): `done`=1, `pass` ← (err_cnt==0) → IDLE.
- `err_cnt` saturates at 2^ERR_W−1. Once it saturates, further mismatches leave it unchanged.
- `pass` and `err_cnt` hold after DONE until the next accepted `start`.
- `a`,`b` hold the last vector (1,1) after a run; they return to 0 only on reset.
- `start` is ignored outside IDLE. No queuing.
- `y` is sampled only in CHECK. Changes on `y` at any other time have no effect.

## Timing
- Reset values: `a`=0, `b`=0, `busy`=0, `done`=0, `pass`=0, `err_cnt`=0, `fail_vec`=0, `fail_mask`=0. State is IDLE.
- Per vector: SETTLE+2 cycles.
- `done` rises 4·(SETTLE+2)+1 cycles after the edge that samples `start`. That is 17 cycles at SETTLE=2.
- `busy` rises the cycle after `start` is sampled and falls in the DONE cycle.
- `y` is sampled SETTLE+1 edges after `a`/`b` update.
- Reset mid-run: all outputs return to reset values immediately. No `done` pulse is produced for the aborted run.
- `start` high in the DONE cycle is ignored. A new run needs `start` high while in IDLE.
- `start` held high continuously starts back-to-back runs: each IDLE cycle accepts it.

## Configuration
- `LGC_FAIL_CAPTURE_EN` defined:
  - `fail_vec` and `fail_mask` ports exist.
  - On the first CHECK with a nonzero mismatch in a run, they capture {a,b} and y^expected.
  - Later failures in the same run do not overwrite them.
  - They clear on accepted `start`.
- Undefined: both ports and their registers are absent. All other behaviour is identical.

## Test plan
- Ideal gate model on `y`, SETTLE=2, pulse `start` → `done` pulses at cycle 17, `pass`=1, `err_cnt`=0, `a`/`b` end at 1/1.
- y5 stuck at 0 → mismatches at vectors 01 and 10; `err_cnt`=2, `pass`=0. With the macro: `fail_vec`=01, `fail_mask`=7'b0010000.
- All `y` bits inverted from expected → `err_cnt`=28, `pass`=0. With ERR_W=3 the same stimulus gives `err_cnt`=7 (saturated).
- `start` pulsed again during the WAIT of vector 10 → ignored; a single `done` at the original cycle and results unchanged.
- `rst_n` asserted during CHECK of vector 01 → all outputs are reset values next sample, no `done`. A subsequent `start` with the ideal model gives `pass`=1.
- Build without `LGC_FAIL_CAPTURE_EN`, repeat the stuck-y5 case → `err_cnt`=2, `pass`=0, and the capture ports are absent.

Source files
------------

// File: rtl/logicgates_checker.sv
// Stimulus/response checker for the two-input gate block: walks a/b through 00..11 and scores y.
// Optional first-failure capture ports are built when LGC_FAIL_CAPTURE_EN is defined.
module logicgates_checker #(
    parameter int unsigned SETTLE = 2,
    parameter int unsigned ERR_W  = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start_i,
    output logic             a_o,
    output logic             b_o,
    input  logic [6:0]       y_i,
    output logic             busy_o,
    output logic             done_o,
    output logic             pass_o,
    output logic [ERR_W-1:0] err_cnt_o
`ifdef LGC_FAIL_CAPTURE_EN
    ,
    output logic [1:0]       fail_vec_o,
    output logic [6:0]       fail_mask_o
`endif
);

    localparam int unsigned SumW = ERR_W + 3;

    typedef enum logic [2:0] {StIdle, StApply, StWait, StCheck, StDone} state_e;

    state_e           state_q;
    logic [1:0]       idx_q;
    logic [7:0]       wait_q;
    logic             a_q, b_q;
    logic             busy_q, done_q, pass_q;
    logic [ERR_W-1:0] err_q;
`ifdef LGC_FAIL_CAPTURE_EN
    logic [1:0]       fail_vec_q;
    logic [6:0]       fail_mask_q;
`endif

    logic [6:0]       exp_y;
    logic [6:0]       diff;
    logic [3:0]       mism;
    logic [SumW-1:0]  err_sum;
    logic [ERR_W-1:0] err_cnt_d;

    always_comb begin
        exp_y = {~a_q, ~(a_q ^ b_q), a_q ^ b_q, ~(a_q | b_q), ~(a_q & b_q), a_q | b_q, a_q & b_q};
        diff  = y_i ^ exp_y;
        mism  = 4'd0;
        for (int i = 0; i < 7; i++) begin
            mism = mism + 4'(diff[i]);
        end
        // Widened sum so the saturation test cannot itself wrap.
        err_sum   = SumW'(err_q) + SumW'(mism);
        err_cnt_d = (err_sum > SumW'({ERR_W{1'b1}})) ? {ERR_W{1'b1}} : err_sum[ERR_W-1:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            idx_q       <= 2'd0;
            wait_q      <= 8'd0;
            a_q         <= 1'b0;
            b_q         <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            pass_q      <= 1'b0;
            err_q       <= '0;
`ifdef LGC_FAIL_CAPTURE_EN
            fail_vec_q  <= 2'd0;
            fail_mask_q <= 7'd0;
`endif
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (start_i) begin
                        state_q     <= StApply;
                        busy_q      <= 1'b1;
                        pass_q      <= 1'b0;
                        err_q       <= '0;
                        idx_q       <= 2'd0;
`ifdef LGC_FAIL_CAPTURE_EN
                        fail_vec_q  <= 2'd0;
                        fail_mask_q <= 7'd0;
`endif
                    end
                end
                StApply: begin
                    a_q     <= idx_q[1];
                    b_q     <= idx_q[0];
                    wait_q  <= 8'(SETTLE - 1);
                    state_q <= StWait;
                end
                StWait: begin
                    if (wait_q == 8'd0) begin
                        state_q <= StCheck;
                    end else begin
                        wait_q <= wait_q - 8'd1;
                    end
                end
                StCheck: begin
                    err_q <= err_cnt_d;
`ifdef LGC_FAIL_CAPTURE_EN
                    // A captured mask is never zero, so zero means nothing captured yet.
                    if (mism != 4'd0 && fail_mask_q == 7'd0) begin
                        fail_vec_q  <= {a_q, b_q};
                        fail_mask_q <= diff;
                    end
`endif
                    if (idx_q != 2'd3) begin
                        idx_q   <= idx_q + 2'd1;
                        state_q <= StApply;
                    end else begin
                        busy_q  <= 1'b0;
                        state_q <= StDone;
                    end
                end
                StDone: begin
                    done_q  <= 1'b1;
                    pass_q  <= (err_q == '0);
                    state_q <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign a_o       = a_q;
    assign b_o       = b_q;
    assign busy_o    = busy_q;
    assign done_o    = done_q;
    assign pass_o    = pass_q;
    assign err_cnt_o = err_q;
`ifdef LGC_FAIL_CAPTURE_EN
    assign fail_vec_o  = fail_vec_q;
    assign fail_mask_o = fail_mask_q;
`endif

endmodule
